// File: rtl/adc_fmt_pkg.sv
// rtl/adc_fmt_pkg.sv - shared encodings and index helpers for the ADC sample formatter
package adc_fmt_pkg;

  // pattern_sel encodings; 3 falls back to live ADC data
  localparam logic [1:0] PAT_ADC   = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_FIXED = 2'd2;

  // Source lane for output slot when the lanes carry ch interleaved channels:
  // consecutive slots walk across channels, each channel owning lanes/ch lanes.
  function automatic int unsigned lane_index(input int unsigned slot,
                                             input int unsigned ch,
                                             input int unsigned lanes);
    return (slot % ch) * (lanes / ch) + slot / ch;
  endfunction

  // Limit log2(channel count) to what the build supports
  function automatic logic [1:0] clamp_mode(input logic [1:0] mode,
                                            input logic [1:0] max_log2);
    return (mode > max_log2) ? max_log2 : mode;
  endfunction

endpackage

// File: rtl/adc_sample_formatter_if.sv
// rtl/adc_sample_formatter_if.sv - sample word in / packed beat out bundle
interface adc_sample_formatter_if #(
  parameter int LANES    = 8,
  parameter int SAMPLE_W = 8,
  parameter int PACK     = 2
);

  logic                              in_valid;
  logic [LANES*SAMPLE_W-1:0]         in_data;
  logic                              out_valid;
  logic [PACK*LANES*SAMPLE_W-1:0]    out_data;
  logic                              out_first;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data,
    input  out_first
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data,
    output out_first
  );

endinterface

// File: rtl/adc_cfg_sync.sv
// rtl/adc_cfg_sync.sv - config synchronisers, change detection and guard counter
module adc_cfg_sync
  import adc_fmt_pkg::*;
#(
  parameter int GUARD = 2
) (
  input  logic       adc_divclk,
  input  logic       adc_aresetn,
  input  logic [1:0] ch_mode_async,
  input  logic [1:0] pattern_sel_async,
  input  logic       in_valid,
  output logic       apply,
  output logic       discard,
  output logic [1:0] cfg_mode,
  output logic [1:0] cfg_pat,
  output logic [1:0] next_pat
);

  localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

  logic [3:0]    sync1, sync2, sync3;
  logic [3:0]    active;
  logic [GW-1:0] guard_cnt;

  // New config takes effect on the edge after the synced value differs
  assign apply    = (sync3 != active);
  // The word on the change edge belongs to neither config, so it is dropped too
  assign discard  = in_valid && (apply || (guard_cnt != '0));
  assign cfg_mode = active[3:2];
  assign cfg_pat  = active[1:0];
  assign next_pat = sync3[1:0];

  // Three-flop synchronisers, active config register and guard countdown
  always_ff @(posedge adc_divclk or negedge adc_aresetn) begin
    if (!adc_aresetn) begin
      sync1     <= '0;
      sync2     <= '0;
      sync3     <= '0;
      active    <= '0;
      guard_cnt <= '0;
    end else begin
      sync1 <= {ch_mode_async, pattern_sel_async};
      sync2 <= sync1;
      sync3 <= sync2;
      if (apply) begin
        active    <= sync3;
        guard_cnt <= GW'(GUARD);
      end else if (in_valid && (guard_cnt != '0)) begin
        guard_cnt <= guard_cnt - GW'(1);
      end
    end
  end

endmodule

// File: rtl/adc_sample_formatter.sv
// rtl/adc_sample_formatter.sv - ADC lane conversion, interleave reorder, test patterns and packing
module adc_sample_formatter
  import adc_fmt_pkg::*;
#(
  parameter int               LANES    = 8,
  parameter int               SAMPLE_W = 8,
  parameter int               MAX_CH   = 4,
  parameter int               PACK     = 2,
  parameter int               GUARD    = 2,
  parameter logic [LANES-1:0] POL_INV  = 8'b1111_1011
) (
  input  logic                   adc_divclk,
  input  logic                   adc_aresetn,
  adc_sample_formatter_if.slave  bus,
  input  logic [1:0]             ch_mode_async,
  input  logic [1:0]             pattern_sel_async,
  output logic [1:0]             mode_active,
  output logic [15:0]            drop_count
);

  localparam int         WORD_W   = LANES * SAMPLE_W;
  localparam int         LW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int         PW       = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [1:0] MAX_LOG2 = 2'($clog2(MAX_CH));
  localparam logic [PW-1:0] LAST_SLOT = PW'(PACK - 1);

  logic       apply, discard, accept;
  logic [1:0] cfg_mode, cfg_pat, next_pat;

  logic [SAMPLE_W-1:0] conv  [LANES];
  logic [SAMPLE_W-1:0] reord [LANES];
  logic [LW-1:0]       src_idx;
  logic [WORD_W-1:0]   fmt_word;
  logic [SAMPLE_W-1:0] ramp;

  logic                          s1_valid;
  logic [WORD_W-1:0]             s1_data;
  logic [PW-1:0]                 pack_cnt;
  logic [PACK-1:0][WORD_W-1:0]   pack_buf, beat_next;
  logic                          first_armed;
  logic [7:0]                    drop_inc;
  logic [16:0]                   drop_sum;

  adc_cfg_sync #(.GUARD(GUARD)) u_cfg_sync (
    .adc_divclk        (adc_divclk),
    .adc_aresetn       (adc_aresetn),
    .ch_mode_async     (ch_mode_async),
    .pattern_sel_async (pattern_sel_async),
    .in_valid          (bus.in_valid),
    .apply             (apply),
    .discard           (discard),
    .cfg_mode          (cfg_mode),
    .cfg_pat           (cfg_pat),
    .next_pat          (next_pat)
  );

  assign mode_active = clamp_mode(cfg_mode, MAX_LOG2);
  assign accept      = bus.in_valid && !discard;

  // Offset binary to two's complement, channel reorder, then pattern substitution
  always_comb begin
    src_idx  = '0;
    fmt_word = '0;
    for (int i = 0; i < LANES; i++) begin
      conv[i]  = bus.in_data[i*SAMPLE_W +: SAMPLE_W];
      if (POL_INV[i]) begin
        conv[i][SAMPLE_W-2:0] = ~conv[i][SAMPLE_W-2:0];
      end else begin
        conv[i][SAMPLE_W-1]   = ~conv[i][SAMPLE_W-1];
      end
      reord[i] = conv[i];
    end
    for (int m = 0; m <= int'(MAX_LOG2); m++) begin
      if (int'(mode_active) == m) begin
        for (int j = 0; j < LANES; j++) begin
          src_idx  = LW'(lane_index(j, 1 << m, LANES));
          reord[j] = conv[src_idx];
        end
      end
    end
    for (int j = 0; j < LANES; j++) begin
      case (cfg_pat)
        PAT_RAMP:  fmt_word[j*SAMPLE_W +: SAMPLE_W] = ramp;
        PAT_FIXED: fmt_word[j*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(j * 32'h11);
        default:   fmt_word[j*SAMPLE_W +: SAMPLE_W] = reord[j];
      endcase
    end
  end

  // Beat as it will look once the staged word lands in its slot
  always_comb begin
    beat_next           = pack_buf;
    beat_next[pack_cnt] = s1_data;
  end

  // Words lost this cycle: a discarded input plus, on a config change,
  // the partial pack and any word still sitting in stage 1
  always_comb begin
    drop_inc = 8'(discard);
    if (apply) begin
      drop_inc = drop_inc + 8'(pack_cnt) + 8'(s1_valid);
    end
    drop_sum = {1'b0, drop_count} + 17'(drop_inc);
  end

  // Stage 1: register the formatted word and advance the ramp
  always_ff @(posedge adc_divclk or negedge adc_aresetn) begin
    if (!adc_aresetn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      ramp     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= fmt_word;
      end
      if (apply && (next_pat == PAT_RAMP)) begin
        ramp <= '0;
      end else if (accept) begin
        ramp <= ramp + SAMPLE_W'(1);
      end
    end
  end

  // Stage 2: pack words into a beat, strobe it, track first beat and drops
  always_ff @(posedge adc_divclk or negedge adc_aresetn) begin
    if (!adc_aresetn) begin
      pack_cnt      <= '0;
      pack_buf      <= '0;
      first_armed   <= 1'b1;
      drop_count    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_first <= 1'b0;
    end else begin
      drop_count    <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      bus.out_valid <= 1'b0;
      bus.out_first <= 1'b0;
      if (apply) begin
        pack_cnt    <= '0;
        first_armed <= 1'b1;
      end else if (s1_valid) begin
        pack_buf <= beat_next;
        if (pack_cnt == LAST_SLOT) begin
          pack_cnt      <= '0;
          bus.out_valid <= 1'b1;
          bus.out_data  <= beat_next;
          bus.out_first <= first_armed;
          first_armed   <= 1'b0;
        end else begin
          pack_cnt <= pack_cnt + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_formatter.sv
// tb/tb_adc_sample_formatter.sv - randomized self-checking bench for adc_sample_formatter
module tb_adc_sample_formatter;

  localparam int         PACK    = 2;
  localparam int         GUARD   = 2;
  localparam int         MAX_CH  = 4;
  localparam logic [7:0] POL_INV = 8'b1111_1011;

  typedef struct {
    logic [127:0] data;
    logic         first;
    int           cyc;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ch_mode_async = 2'd0;
  logic [1:0] pattern_sel_async = 2'd0;
  logic [1:0] mode_active;
  logic [15:0] drop_count;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  // behavioural model state
  int          m_mode = 0, m_pat = 0, m_guard = 0, m_drop = 0;
  logic        m_first = 1'b1;
  logic [7:0]  m_ramp = 8'd0;
  logic [63:0] m_part[$];
  beat_t       exp_q[$];

  adc_sample_formatter_if #(.LANES(8), .SAMPLE_W(8), .PACK(PACK)) bus();

  adc_sample_formatter dut (
    .adc_divclk        (clk),
    .adc_aresetn       (rst_n),
    .bus               (bus),
    .ch_mode_async     (ch_mode_async),
    .pattern_sel_async (pattern_sel_async),
    .mode_active       (mode_active),
    .drop_count        (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_word(input logic [63:0] d, input int mode,
                                             input int pat, input logic [7:0] rv);
    int          ch = 1 << mode;
    logic [7:0]  conv [8];
    logic [7:0]  b;
    logic [63:0] w = '0;
    if (ch > MAX_CH) ch = MAX_CH;
    for (int i = 0; i < 8; i++) begin
      b = d[i*8 +: 8];
      conv[i] = POL_INV[i] ? (b ^ 8'h7F) : (b ^ 8'h80);
    end
    for (int j = 0; j < 8; j++) begin
      case (pat)
        1:       w[j*8 +: 8] = rv;
        2:       w[j*8 +: 8] = 8'(j * 17);
        default: w[j*8 +: 8] = conv[(j % ch) * (8 / ch) + j / ch];
      endcase
    end
    return w;
  endfunction

  function automatic void add_drop(input int n);
    m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
  endfunction

  // Beat completion strobes on exactly the predicted cycle, nowhere else
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check("strobe", 128'(bus.out_valid), 128'(1));
        check("beat_data", bus.out_data, exp_q[0].data);
        check("beat_first", 128'(bus.out_first), 128'(exp_q[0].first));
        void'(exp_q.pop_front());
      end else begin
        check("idle_strobe", 128'(bus.out_valid), 128'(0));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [63:0] d);
    beat_t       bt;
    logic [127:0] bd;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    if (m_guard > 0) begin
      m_guard--;
      add_drop(1);
    end else begin
      m_part.push_back(model_word(d, m_mode, m_pat, m_ramp));
      m_ramp = m_ramp + 8'd1;
      if (m_part.size() == PACK) begin
        for (int k = 0; k < PACK; k++) bd[k*64 +: 64] = m_part[k];
        bt.data  = bd;
        bt.first = m_first;
        bt.cyc   = cyc + 2;
        exp_q.push_back(bt);
        m_first = 1'b0;
        m_part.delete();
      end
    end
  endtask

  task automatic set_cfg(input int m, input int p);
    idle(3);
    ch_mode_async     = 2'(m);
    pattern_sel_async = 2'(p);
    if (m != m_mode || p != m_pat) begin
      add_drop(m_part.size());
      m_part.delete();
      m_guard = GUARD;
      m_first = 1'b1;
      if (p == 1) m_ramp = 8'd0;
      m_mode = m;
      m_pat  = p;
    end
    idle(6);
    check("mode_active", 128'(mode_active), 128'((m > 2) ? 2 : m));
    check("drop_count", 128'(drop_count), 128'(m_drop));
  endtask

  task automatic flush_guard();
    repeat (GUARD) send_word(64'({$urandom, $urandom}));
  endtask

  initial begin
    int d0;
    logic [63:0] alt_w[4];
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #12;
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_out_data", bus.out_data, 128'(0));
    check("rst_out_first", 128'(bus.out_first), 128'(0));
    check("rst_mode", 128'(mode_active), 128'(0));
    check("rst_drop", 128'(drop_count), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // 1ch conversion of mid-scale samples
    send_word({8{8'h80}});
    send_word({8{8'h80}});
    idle(4);
    check("t1_data", bus.out_data, {2{64'hFFFFFFFFFF00FFFF}});

    // interleave orderings
    for (int m = 1; m < 4; m++) begin
      set_cfg(m, 0);
      flush_guard();
      send_word(64'h78797A7B7C827E7F);
      send_word(64'h78797A7B7C827E7F);
      idle(4);
      check("t2_order", bus.out_data,
            (m == 1) ? {2{64'h0703060205010400}} : {2{64'h0705030106040200}});
      repeat (6) send_word(64'({$urandom, $urandom}));
    end

    // partial pack dropped on change, then guard words
    set_cfg(1, 0);
    flush_guard();
    d0 = m_drop;
    send_word(64'({$urandom, $urandom}));
    set_cfg(2, 0);
    flush_guard();
    idle(2);
    check("t3_drop_delta", 128'(drop_count), 128'(d0 + 3));
    send_word(64'h78797A7B7C827E7F);
    send_word(64'h78797A7B7C827E7F);

    // ramp and fixed patterns
    set_cfg(2, 1);
    flush_guard();
    repeat (4) send_word(64'({$urandom, $urandom}));
    idle(4);
    check("t4_ramp", bus.out_data, {{8{8'h03}}, {8{8'h02}}});
    set_cfg(2, 2);
    flush_guard();
    repeat (2) send_word(64'({$urandom, $urandom}));
    idle(4);
    check("t4_fixed", bus.out_data, {2{64'h7766554433221100}});

    // continuous then alternating valid with the same words
    set_cfg(1, 3);
    flush_guard();
    for (int k = 0; k < 4; k++) alt_w[k] = 64'({$urandom, $urandom});
    for (int k = 0; k < 4; k++) send_word(alt_w[k]);
    for (int k = 0; k < 4; k++) begin
      send_word(alt_w[k]);
      idle(1);
    end

    // randomized traffic with occasional config changes
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 11) == 0) set_cfg($urandom_range(0, 3), $urandom_range(0, 3));
      send_word(64'({$urandom, $urandom}));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    // asynchronous reset in the middle of a pack
    set_cfg(0, 0);
    flush_guard();
    send_word(64'({$urandom, $urandom}));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 128'(bus.out_valid), 128'(0));
    check("arst_drop", 128'(drop_count), 128'(0));
    bus.in_valid = 1'b0;
    exp_q.delete();
    m_part.delete();
    m_drop = 0; m_guard = 0; m_first = 1'b1; m_ramp = 8'd0; m_mode = 0; m_pat = 0;
    idle(3);
    rst_n = 1'b1;
    send_word(64'({$urandom, $urandom}));
    send_word(64'({$urandom, $urandom}));
    idle(5);
    check("pending_beats", 128'(exp_q.size()), 128'(0));
    check("final_drop", 128'(drop_count), 128'(m_drop));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
